instr_fetch_unit: RTL and testbench

Fetch-stage initiator that drives byte addresses into the combinational instruction memory and registers returned words into the IF/ID pipeline register. It owns the program counter. It advances the PC under a valid/ready handshake with decode, accepts branch/jump redirects from later stages, and stops permanently on a halt word. It sits between the PC logic and the decode stage, opposite the instruction memory.

---
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and fills the IF/ID register.
// Optional misaligned-redirect trap is compiled in with IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic [31:0] programCounterOut,
  input  logic [31:0] instructionIn,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  input  logic        idReady,
  output logic        idValid,
  output logic [31:0] idInstruction,
  output logic [31:0] idPcPlus4,
  output logic        halted,
  output logic [31:0] fetchCount,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic [1:0]  dbgState
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STALL      = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        halted_q, halted_d;
  logic [31:0] count_q, count_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] pc_seq;
  logic [31:0] target_wrapped;
  logic        accept;
  logic        load_ok;
  logic [31:0] count_inc;

  assign pc_seq         = (pc_q + 32'd4) % MEM_BYTES;
  assign target_wrapped = redirectTarget % MEM_BYTES;
  // Handshake: decode takes the IF/ID word on a cycle where idValid && idReady;
  // idValid never drops without that accept unless a redirect flushes it.
  assign accept         = id_valid_q && idReady;
  assign load_ok        = !id_valid_q || idReady;
  assign count_inc      = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;
    halted_d     = halted_q;
    count_d      = count_q;
    misaligned_d = misaligned_q;

    case (state_q)
      RUN, STALL: begin
        if (load_ok) begin
          id_valid_d = 1'b1;
          id_instr_d = instructionIn;
          id_pc4_d   = pc_seq;
          pc_d       = pc_seq;
          if (accept) count_d = count_inc;
          state_d    = (instructionIn == HALT_WORD) ? HALT_DRAIN : RUN;
        end else begin
          state_d = STALL;
        end
      end
      HALT_DRAIN: begin
        if (accept) begin
          id_valid_d = 1'b0;
          halted_d   = 1'b1;
          count_d    = count_inc;
          state_d    = HALTED;
        end
      end
      default: ;
    endcase

    // A redirect overrides whatever the state logic chose, including the accept count.
    if (redirectValid && (state_q != HALTED)) begin
      id_valid_d = 1'b0;
      id_instr_d = id_instr_q;
      id_pc4_d   = id_pc4_q;
      count_d    = count_q;
      halted_d   = halted_q;
`ifdef IFU_MISALIGN_TRAP_EN
      if (redirectTarget[1:0] != 2'b00) begin
        pc_d         = pc_q;
        misaligned_d = 1'b1;
        halted_d     = 1'b1;
        state_d      = HALTED;
      end else begin
        pc_d    = target_wrapped;
        state_d = RUN;
      end
`else
      pc_d    = target_wrapped;
      state_d = RUN;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'd0;
      id_pc4_q     <= 32'd0;
      halted_q     <= 1'b0;
      count_q      <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign programCounterOut = pc_q;
  assign idValid           = id_valid_q;
  assign idInstruction     = id_instr_q;
  assign idPcPlus4         = id_pc4_q;
  assign halted            = halted_q;
  assign fetchCount        = count_q;
  assign dbgState          = state_q;
`ifdef IFU_MISALIGN_TRAP_EN
  assign misaligned        = misaligned_q;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned_q ^ misaligned_d;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioral instruction memory.
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [1:0]  S_RUN = 2'd0, S_STALL = 2'd1, S_DRAIN = 2'd2, S_HALTED = 2'd3;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] programCounterOut;
  logic [31:0] instructionIn;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        idReady;
  logic        idValid;
  logic [31:0] idInstruction;
  logic [31:0] idPcPlus4;
  logic        halted;
  logic [31:0] fetchCount;
  logic [1:0]  dbgState;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  logic [31:0] mem [0:1023];
  int checks;
  int failures;

  assign instructionIn = mem[programCounterOut[11:2]];

  instr_fetch_unit dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .programCounterOut(programCounterOut),
    .instructionIn(instructionIn),
    .redirectValid(redirectValid),
    .redirectTarget(redirectTarget),
    .idReady(idReady),
    .idValid(idValid),
    .idInstruction(idInstruction),
    .idPcPlus4(idPcPlus4),
    .halted(halted),
    .fetchCount(fetchCount),
`ifdef IFU_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .dbgState(dbgState)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0]    = 32'h11;
    mem[1]    = 32'h22;
    mem[2]    = 32'h33;
    mem[3]    = 32'h44;
    mem[16]   = 32'hA0;
    mem[17]   = 32'hA1;
    mem[1023] = 32'hEE;
  endtask

  task automatic do_reset();
    Rst_n          = 1'b0;
    redirectValid  = 1'b0;
    redirectTarget = 32'd0;
    idReady        = 1'b1;
    step();
    step();
    check("rst_pc", programCounterOut, 32'd0);
    check("rst_valid", idValid, 0);
    check("rst_instr", idInstruction, 32'd0);
    check("rst_pc4", idPcPlus4, 32'd0);
    check("rst_halted", halted, 0);
    check("rst_count", fetchCount, 32'd0);
    check("rst_state", dbgState, S_RUN);
`ifdef IFU_MISALIGN_TRAP_EN
    check("rst_misaligned", misaligned, 0);
`endif
    Rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Rst_n = 1'b0;
    idReady = 1'b1;
    redirectValid = 1'b0;
    redirectTarget = 32'd0;

    // Streaming fetch from reset
    init_mem();
    do_reset();
    step();
    check("t1_valid", idValid, 1);
    check("t1_instr0", idInstruction, 32'h11);
    check("t1_pc4_0", idPcPlus4, 32'd4);
    check("t1_pc0", programCounterOut, 32'd4);
    step();
    check("t1_instr1", idInstruction, 32'h22);
    check("t1_pc4_1", idPcPlus4, 32'd8);
    step();
    check("t1_instr2", idInstruction, 32'h33);
    check("t1_pc4_2", idPcPlus4, 32'd12);
    check("t1_count2", fetchCount, 32'd2);
    step();
    check("t1_instr3", idInstruction, 32'h44);
    check("t1_count3", fetchCount, 32'd3);
    check("t1_pc3", programCounterOut, 32'd16);

    // Stall for three cycles holding 0x22
    do_reset();
    step();
    step();
    check("t2_pre_pc", programCounterOut, 32'd8);
    check("t2_pre_instr", idInstruction, 32'h22);
    check("t2_pre_count", fetchCount, 32'd1);
    idReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_pc", programCounterOut, 32'd8);
      check("t2_stall_instr", idInstruction, 32'h22);
      check("t2_stall_count", fetchCount, 32'd1);
      check("t2_stall_state", dbgState, S_STALL);
    end
    idReady = 1'b1;
    step();
    check("t2_rel_instr", idInstruction, 32'h33);
    check("t2_rel_pc", programCounterOut, 32'd12);
    check("t2_rel_count", fetchCount, 32'd2);

    // Redirect during a stall drops the stalled word
    idReady = 1'b0;
    step();
    check("t3_stall_state", dbgState, S_STALL);
    redirectValid = 1'b1;
    redirectTarget = 32'h40;
    step();
    check("t3_redir_pc", programCounterOut, 32'h40);
    check("t3_redir_valid", idValid, 0);
    check("t3_redir_count", fetchCount, 32'd2);
    redirectValid = 1'b0;
    step();
    check("t3_tgt_valid", idValid, 1);
    check("t3_tgt_instr", idInstruction, 32'hA0);
    check("t3_tgt_pc", programCounterOut, 32'h44);
    check("t3_tgt_count", fetchCount, 32'd2);

    // PC wrap at the top of memory, and target wrap
    redirectValid = 1'b1;
    redirectTarget = 32'hFFC;
    step();
    check("t4_pc_top", programCounterOut, 32'hFFC);
    redirectValid = 1'b0;
    idReady = 1'b1;
    step();
    check("t4_top_instr", idInstruction, 32'hEE);
    check("t4_top_pc4", idPcPlus4, 32'd0);
    check("t4_wrap_pc", programCounterOut, 32'd0);
    step();
    check("t4_wrap_instr", idInstruction, 32'h11);
    check("t4_wrap_pc4", idPcPlus4, 32'd4);
    check("t4_wrap_count", fetchCount, 32'd3);
    redirectValid = 1'b1;
    redirectTarget = 32'h1008;
    step();
    check("t4_tgtwrap_pc", programCounterOut, 32'd8);
    check("t4_tgtwrap_valid", idValid, 0);
    check("t4_drop_count", fetchCount, 32'd3);
    redirectValid = 1'b0;
    step();
    check("t4_tgtwrap_instr", idInstruction, 32'h33);
    check("t4_tgtwrap_pc4", idPcPlus4, 32'd12);

    // Halt word at address 12
    init_mem();
    mem[3] = HALT;
    do_reset();
    step();
    step();
    step();
    step();
    check("t5_halt_loaded", idInstruction, HALT);
    check("t5_halt_valid", idValid, 1);
    check("t5_drain_pc", programCounterOut, 32'd16);
    check("t5_drain_state", dbgState, S_DRAIN);
    check("t5_drain_halted", halted, 0);
    check("t5_drain_count", fetchCount, 32'd3);
    step();
    check("t5_halted", halted, 1);
    check("t5_halted_valid", idValid, 0);
    check("t5_halted_count", fetchCount, 32'd4);
    check("t5_halted_state", dbgState, S_HALTED);
    redirectValid = 1'b1;
    redirectTarget = 32'h40;
    step();
    check("t5_ign_pc", programCounterOut, 32'd16);
    check("t5_ign_halted", halted, 1);
    check("t5_ign_valid", idValid, 0);
    step();
    check("t5_ign_pc2", programCounterOut, 32'd16);
    redirectValid = 1'b0;
    Rst_n = 1'b0;
    #1;
    check("t5_async_halted", halted, 0);
    check("t5_async_pc", programCounterOut, 32'd0);
    check("t5_async_count", fetchCount, 32'd0);

    // Redirect in HALT_DRAIN squashes the halt
    do_reset();
    step();
    step();
    step();
    step();
    idReady = 1'b0;
    step();
    check("t5b_drain_valid", idValid, 1);
    check("t5b_drain_state", dbgState, S_DRAIN);
    check("t5b_drain_pc", programCounterOut, 32'd16);
    check("t5b_drain_halted", halted, 0);
    redirectValid = 1'b1;
    redirectTarget = 32'h40;
    idReady = 1'b1;
    step();
    check("t5b_redir_pc", programCounterOut, 32'h40);
    check("t5b_redir_valid", idValid, 0);
    check("t5b_redir_halted", halted, 0);
    check("t5b_redir_count", fetchCount, 32'd3);
    check("t5b_redir_state", dbgState, S_RUN);
    redirectValid = 1'b0;
    step();
    check("t5b_tgt_instr", idInstruction, 32'hA0);
    check("t5b_tgt_pc", programCounterOut, 32'h44);
    check("t5b_tgt_halted", halted, 0);

`ifdef IFU_MISALIGN_TRAP_EN
    // Misaligned redirect traps
    init_mem();
    do_reset();
    step();
    step();
    check("t6_pre_pc", programCounterOut, 32'd8);
    redirectValid = 1'b1;
    redirectTarget = 32'h42;
    step();
    check("t6_misaligned", misaligned, 1);
    check("t6_halted", halted, 1);
    check("t6_pc", programCounterOut, 32'd8);
    check("t6_valid", idValid, 0);
    redirectValid = 1'b0;
    step();
    check("t6_sticky", misaligned, 1);
    check("t6_pc_hold", programCounterOut, 32'd8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
